// File: rtl/keypress_pkg.sv
// keypress_pkg: shared definitions for the keypress bank.
//   kp_state_e   per-channel FSM state (IDLE / DOWN / REPEAT)
//   MODE_*       encodings of the bank-wide mode input
//   kp_max       constant helper used to size the repeat timer
package keypress_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // key released
        DOWN   = 2'd1,   // key held, waiting for first auto-repeat
        REPEAT = 2'd2    // key held, pulsing every REP_PER cycles
    } kp_state_e;

    localparam logic MODE_RELEASE = 1'b0;   // pulse when the key is let go
    localparam logic MODE_PRESS   = 1'b1;   // pulse on press, plus auto-repeat

    function automatic int kp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypress_chan.sv
// keypress_chan: one key channel -- synchronizer, debouncer, pulse/repeat FSM.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   in          raw asynchronous key level (1 = pressed)
//   mode        MODE_RELEASE / MODE_PRESS, sampled every edge
//   out         one-cycle keypress pulse
//   held        debounced key level
module keypress_chan
    import keypress_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int REP_DLY   = 0,
    parameter int REP_PER   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic mode,
    output logic out,
    output logic held
);

    if (DB_CYCLES < 1 || REP_PER < 1 || REP_DLY < 0) begin : g_bad_param
        $error("keypress_chan: DB_CYCLES and REP_PER must be >= 1, REP_DLY >= 0");
    end

    localparam int DW     = $clog2(DB_CYCLES + 1);
    localparam int RW     = $clog2(kp_max(REP_DLY, REP_PER) + 1);
    localparam bit REP_EN = (REP_DLY > 0);

    // Counters stop at these terminal values, so they never wrap.
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_EN ? REP_DLY - 1 : 0);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

    logic            s1, s2;
    logic [DW-1:0]   dbc;
    logic [RW-1:0]   rcnt;
    kp_state_e       state;
    logic            flip;

    // held toggles on the DB_CYCLES-th consecutive edge of disagreement.
    always_comb begin
        flip = (s2 != held) && (dbc == DB_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            held  <= 1'b0;
            dbc   <= '0;
            rcnt  <= '0;
            state <= IDLE;
            out   <= 1'b0;
        end else begin
            s1  <= in;
            s2  <= s1;
            out <= 1'b0;

            if (flip || (s2 == held)) dbc <= '0;
            else                      dbc <= dbc + 1'b1;
            if (flip) held <= ~held;

            unique case (state)
                IDLE: begin
                    // held is 0 here, so a flip is always a press.
                    if (flip) begin
                        state <= DOWN;
                        rcnt  <= '0;
                        out   <= (mode == MODE_PRESS);
                    end
                end
                DOWN: begin
                    if (flip) begin
                        state <= IDLE;
                        out   <= (mode == MODE_RELEASE);
                    end else if (mode == MODE_RELEASE) begin
                        rcnt <= '0;
                    end else if (REP_EN) begin
                        if (rcnt == DLY_LAST) begin
                            state <= REPEAT;
                            rcnt  <= '0;
                            out   <= 1'b1;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (flip) begin
                        state <= IDLE;
                        out   <= (mode == MODE_RELEASE);
                    end else if (mode == MODE_RELEASE) begin
                        // Dropping to release mode restarts the whole repeat schedule.
                        state <= DOWN;
                        rcnt  <= '0;
                    end else if (rcnt == PER_LAST) begin
                        rcnt <= '0;
                        out  <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypress_bank.sv
// keypress_bank: N_KEYS independent debounced keys with press/release pulses
// and optional auto-repeat.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   in          raw key levels, one bit per key (1 = pressed)
//   mode        0 = pulse on release, 1 = pulse on press (plus auto-repeat)
//   out         one-cycle keypress pulses, one bit per key
//   held        debounced key levels
module keypress_bank
    import keypress_pkg::*;
#(
    parameter int N_KEYS    = 2,
    parameter int DB_CYCLES = 4,
    parameter int REP_DLY   = 0,
    parameter int REP_PER   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] in,
    input  logic              mode,
    output logic [N_KEYS-1:0] out,
    output logic [N_KEYS-1:0] held
);

    if (N_KEYS < 1) begin : g_bad_param
        $error("keypress_bank: N_KEYS must be >= 1");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        keypress_chan #(
            .DB_CYCLES (DB_CYCLES),
            .REP_DLY   (REP_DLY),
            .REP_PER   (REP_PER)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .in    (in[i]),
            .mode  (mode),
            .out   (out[i]),
            .held  (held[i])
        );
    end

endmodule

// File: tb/tb_keypress_bank.sv
module tb_keypress_bank;
    localparam int NK = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [NK-1:0] in;
    logic [NK-1:0] out;
    logic [NK-1:0] held;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, per key.
    int            m_s1[NK], m_s2[NK], m_held[NK], m_run[NK], m_age[NK];
    logic [NK-1:0] m_out, m_heldv;

    always #5 clk = ~clk;

    keypress_bank #(.N_KEYS(NK), .DB_CYCLES(DB), .REP_DLY(RD), .REP_PER(RP)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .mode  (mode),
        .out   (out),
        .held  (held)
    );

    // Behavioural model of one clock edge: two-sample input delay, run-length
    // debounce, pulses decided from the age (edges since press or since mode
    // last forced a restart).
    task automatic model_edge();
        bit flip;
        for (int k = 0; k < NK; k++) begin
            if (reset) begin
                m_s1[k] = 0; m_s2[k] = 0; m_held[k] = 0; m_run[k] = 0; m_age[k] = 0;
                m_out[k] = 1'b0;
            end else begin
                flip = (m_s2[k] != m_held[k]) && (m_run[k] + 1 == DB);
                m_out[k] = 1'b0;
                if (m_s2[k] != m_held[k] && !flip) m_run[k]++;
                else m_run[k] = 0;
                if (flip) begin
                    m_held[k] = 1 - m_held[k];
                    if (m_held[k] == 1) begin
                        m_out[k] = mode;
                        m_age[k] = 0;
                    end else begin
                        m_out[k] = !mode;
                    end
                end else if (m_held[k] == 1) begin
                    if (!mode) m_age[k] = 0;
                    else begin
                        m_age[k]++;
                        if (RD > 0 && m_age[k] >= RD && (m_age[k] - RD) % RP == 0) m_out[k] = 1'b1;
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = int'(in[k]);
            end
            m_heldv[k] = (m_held[k] == 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiesce();
        in = '0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in = '1; mode = 1'b1;
        repeat (3) begin
            tick();
            n_checks++;
            if ({held, out} !== '0) begin
                n_fail++;
                $display("FAIL reset_state held/out=%b required 0", {held, out});
            end
        end
        in = '0; mode = 1'b0;
        tick();
        reset = 1'b0;
        quiesce();
    endtask

    task automatic test_release_mode();
        int rise_at = -1, fall_at = -1, pulses = 0, pulse_at = -1;
        logic ph = 1'b0;
        mode = 1'b0; in = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) in = 2'b00;
            tick();
            n_checks++;
            if ({held, out} !== {m_heldv, m_out}) begin
                n_fail++;
                $display("FAIL release_model k=%0d held/out=%b required %b", k, {held, out}, {m_heldv, m_out});
            end
            if (held[0] && !ph) rise_at = k;
            if (!held[0] && ph) fall_at = k;
            ph = held[0];
            if (out[0]) begin pulses++; pulse_at = k; end
        end
        n_checks++;
        if (rise_at != 6) begin n_fail++; $display("FAIL release_rise edge=%0d required 6", rise_at); end
        n_checks++;
        if (fall_at != 26) begin n_fail++; $display("FAIL release_fall edge=%0d required 26", fall_at); end
        n_checks++;
        if (pulses != 1 || pulse_at != 26) begin
            n_fail++;
            $display("FAIL release_pulse count=%0d at=%0d required 1 at 26", pulses, pulse_at);
        end
        quiesce();
    endtask

    task automatic test_glitch();
        mode = 1'b1; in = 2'b10;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) in = 2'b00;
            tick();
            n_checks++;
            if (held[1] !== 1'b0 || out[1] !== 1'b0 || {held, out} !== {m_heldv, m_out}) begin
                n_fail++;
                $display("FAIL glitch k=%0d held/out=%b required 0000", k, {held, out});
            end
        end
        quiesce();
    endtask

    task automatic test_repeat();
        int got[$];
        int exp[$];
        mode = 1'b1; in = 2'b01;
        exp.push_back(6);
        for (int t = 6 + RD; t < 46; t += RP) exp.push_back(t);
        for (int k = 1; k <= 60; k++) begin
            if (k == 41) in = 2'b00;
            tick();
            n_checks++;
            if ({held, out} !== {m_heldv, m_out}) begin
                n_fail++;
                $display("FAIL repeat_model k=%0d held/out=%b required %b", k, {held, out}, {m_heldv, m_out});
            end
            if (out[0]) got.push_back(k);
        end
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL repeat_count pulses=%0d required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] != exp[i]) begin
                n_fail++;
                $display("FAIL repeat_edge idx=%0d edge=%0d required %0d", i, got[i], exp[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_simul();
        int both = 0, both_at = -1;
        mode = 1'b1; in = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            if (k == 9) in = 2'b00;
            tick();
            n_checks++;
            if ({held, out} !== {m_heldv, m_out}) begin
                n_fail++;
                $display("FAIL simul_model k=%0d held/out=%b required %b", k, {held, out}, {m_heldv, m_out});
            end
            if (out == 2'b11) begin both++; both_at = k; end
        end
        n_checks++;
        if (both != 1 || both_at != 6) begin
            n_fail++;
            $display("FAIL simul_pulse count=%0d at=%0d required 1 at 6", both, both_at);
        end
        quiesce();
    endtask

    task automatic test_reset_mid();
        int rise_at = -1, pulse_at = -1, pulses = 0;
        logic ph = 1'b0;
        mode = 1'b1; in = 2'b01;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({held, out} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_edge held/out=%b required 0", {held, out});
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if ({held, out} !== {m_heldv, m_out}) begin
                n_fail++;
                $display("FAIL reset_mid_model k=%0d held/out=%b required %b", k, {held, out}, {m_heldv, m_out});
            end
            if (held[0] && !ph) rise_at = k;
            ph = held[0];
            if (out[0]) begin pulses++; pulse_at = k; end
        end
        n_checks++;
        if (rise_at != 6 || pulses != 1 || pulse_at != 6) begin
            n_fail++;
            $display("FAIL reset_mid_press rise=%0d pulses=%0d at=%0d required 6/1/6", rise_at, pulses, pulse_at);
        end
        quiesce();
    endtask

    task automatic test_mode_toggle();
        int got[$];
        int exp[$] = '{6, 16, 21, 36};
        mode = 1'b1; in = 2'b01;
        for (int k = 1; k <= 45; k++) begin
            if (k == 22) mode = 1'b0;
            if (k == 31) in = 2'b00;
            tick();
            n_checks++;
            if ({held, out} !== {m_heldv, m_out}) begin
                n_fail++;
                $display("FAIL toggle_model k=%0d held/out=%b required %b", k, {held, out}, {m_heldv, m_out});
            end
            if (out[0]) got.push_back(k);
        end
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL toggle_count pulses=%0d required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] != exp[i]) begin
                n_fail++;
                $display("FAIL toggle_edge idx=%0d edge=%0d required %0d", i, got[i], exp[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 5) == 0) in = in ^ (NK'(1) << $urandom_range(0, NK - 1));
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            reset = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if ({held, out} !== {m_heldv, m_out}) begin
                n_fail++;
                $display("FAIL random k=%0d in=%b mode=%b held/out=%b required %b", k, in, mode, {held, out}, {m_heldv, m_out});
            end
        end
        reset = 1'b0;
        quiesce();
    endtask

    initial begin
        in = '0; mode = 1'b0; reset = 1'b1;
        m_out = '0; m_heldv = '0;
        test_reset();
        test_release_mode();
        test_glitch();
        test_repeat();
        test_simul();
        test_reset_mid();
        test_mode_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
